// File: rtl/rv64_single_cycle_processor.sv
// Single-cycle RV64I-subset core (ld, sd, add/sub/logic/shift/slt, addi, beq).
// Each rising edge retires exactly one instruction. All memories live inside the core.

module rv64_fetch #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic [63:0] pc_i,
  output logic [31:0] instruction_o
);
  localparam int IW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [31:0]   instr_mem [0:IMEM_DEPTH-1];
  logic [IW-1:0] idx;
  logic          unused_pc;

  // The depth is a power of two, so slicing the word index wraps it modulo the depth.
  assign idx           = pc_i[IW+1:2];
  assign unused_pc     = ^{pc_i[63:IW+2], pc_i[1:0]};
  assign instruction_o = instr_mem[idx];
endmodule

module rv64_decode (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] instruction_i,
  input  logic        reg_write_i,
  input  logic [4:0]  write_reg_i,
  input  logic [63:0] write_data_i,
  output logic [63:0] read_data1_o,
  output logic [63:0] read_data2_o,
  output logic [63:0] imm_ext_o,
  output logic        reg_write_o,
  output logic        alu_src_o,
  output logic [1:0]  alu_op_o,
  output logic        branch_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        mem_to_reg_o
);
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SD = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_B  = 7'b1100011;

  logic [63:0] registers [0:31];
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        r_valid;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];
  assign funct7 = instruction_i[31:25];
  assign rs1    = instruction_i[19:15];
  assign rs2    = instruction_i[24:20];

  // funct7=0100000 is only meaningful for sub and sra; other R-type combinations retire as no-ops.
  assign r_valid = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));

  assign read_data1_o = (rs1 == 5'd0) ? 64'd0 : registers[rs1];
  assign read_data2_o = (rs2 == 5'd0) ? 64'd0 : registers[rs2];

  // Plain always: the array is also preloaded hierarchically from outside the core.
  always @(posedge clk_i) begin
    if (reset_ni && reg_write_i && (write_reg_i != 5'd0)) begin
      registers[write_reg_i] <= write_data_i;
    end
  end

  always_comb begin
    case (opcode)
      OP_SD:   imm_ext_o = {{52{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
      OP_B:    imm_ext_o = {{52{instruction_i[31]}}, instruction_i[7], instruction_i[30:25],
                            instruction_i[11:8], 1'b0};
      default: imm_ext_o = {{52{instruction_i[31]}}, instruction_i[31:20]};
    endcase
  end

  always_comb begin
    reg_write_o  = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = 2'b00;
    branch_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    case (opcode)
      OP_LD: begin
        if (funct3 == 3'b011) begin
          reg_write_o  = 1'b1;
          alu_src_o    = 1'b1;
          mem_read_o   = 1'b1;
          mem_to_reg_o = 1'b1;
        end
      end
      OP_SD: begin
        if (funct3 == 3'b011) begin
          alu_src_o   = 1'b1;
          mem_write_o = 1'b1;
        end
      end
      OP_R: begin
        alu_op_o    = 2'b10;
        reg_write_o = r_valid;
      end
      OP_I: begin
        if (funct3 == 3'b000) begin
          reg_write_o = 1'b1;
          alu_src_o   = 1'b1;
        end
      end
      OP_B: begin
        if (funct3 == 3'b000) begin
          branch_o = 1'b1;
          alu_op_o = 2'b01;
        end
      end
      default: ;
    endcase
  end
endmodule

module rv64_data_mem #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] write_data_i,
  output logic [63:0] read_data_o
);
  localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [63:0]   mem [0:DMEM_DEPTH-1];
  logic [AW-1:0] idx;
  logic          unused_addr;

  assign idx         = addr_i[AW+2:3];
  assign unused_addr = ^{addr_i[63:AW+3], addr_i[2:0]};
  assign read_data_o = mem_read_i ? mem[idx] : 64'd0;

  always @(posedge clk_i) begin
    if (reset_ni && mem_write_i) begin
      mem[idx] <= write_data_i;
    end
  end
endmodule

module rv64_single_cycle_processor #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input logic clk,
  input logic reset
);
  logic [63:0] pc_current;
  logic [63:0] pc_next;
  logic [31:0] instruction;
  logic [63:0] read_data1;
  logic [63:0] read_data2;
  logic [63:0] imm_ext;
  logic        reg_write;
  logic        alu_src;
  logic [1:0]  alu_op;
  logic        branch;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic [63:0] alu_b;
  logic [5:0]  shamt;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [63:0] alu_result;
  logic        zero;
  logic        branch_taken;
  logic [63:0] alu_result_mem;
  logic [63:0] read_data_mem;
  logic [4:0]  write_reg;
  logic [63:0] write_data_reg;
  logic        reg_write_wb;

  rv64_fetch #(.IMEM_DEPTH(IMEM_DEPTH)) if_stage (
    .pc_i          (pc_current),
    .instruction_o (instruction)
  );

  rv64_decode id_stage (
    .clk_i         (clk),
    .reset_ni      (reset),
    .instruction_i (instruction),
    .reg_write_i   (reg_write_wb),
    .write_reg_i   (write_reg),
    .write_data_i  (write_data_reg),
    .read_data1_o  (read_data1),
    .read_data2_o  (read_data2),
    .imm_ext_o     (imm_ext),
    .reg_write_o   (reg_write),
    .alu_src_o     (alu_src),
    .alu_op_o      (alu_op),
    .branch_o      (branch),
    .mem_read_o    (mem_read),
    .mem_write_o   (mem_write),
    .mem_to_reg_o  (mem_to_reg)
  );

  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];
  assign alu_b    = alu_src ? imm_ext : read_data2;
  assign shamt    = alu_b[5:0];

  always_comb begin
    alu_result = read_data1 + alu_b;
    case (alu_op)
      2'b01: alu_result = read_data1 - alu_b;
      2'b10: begin
        case (funct3)
          3'b000:  alu_result = funct7_5 ? (read_data1 - alu_b) : (read_data1 + alu_b);
          3'b001:  alu_result = read_data1 << shamt;
          3'b010:  alu_result = {63'd0, $signed(read_data1) < $signed(alu_b)};
          3'b011:  alu_result = {63'd0, read_data1 < alu_b};
          3'b100:  alu_result = read_data1 ^ alu_b;
          3'b101:  alu_result = funct7_5 ? 64'($signed(read_data1) >>> shamt)
                                         : (read_data1 >> shamt);
          3'b110:  alu_result = read_data1 | alu_b;
          default: alu_result = read_data1 & alu_b;
        endcase
      end
      default: ;
    endcase
  end

  assign zero         = (alu_result == 64'd0);
  assign branch_taken = branch & zero;

  assign alu_result_mem = alu_result;

  rv64_data_mem #(.DMEM_DEPTH(DMEM_DEPTH)) mem_stage (
    .clk_i        (clk),
    .reset_ni     (reset),
    .mem_write_i  (mem_write),
    .mem_read_i   (mem_read),
    .addr_i       (alu_result_mem),
    .write_data_i (read_data2),
    .read_data_o  (read_data_mem)
  );

  assign write_reg      = instruction[11:7];
  assign reg_write_wb   = reg_write;
  assign write_data_reg = mem_to_reg ? read_data_mem : alu_result;

  assign pc_next = branch_taken ? (pc_current + imm_ext) : (pc_current + 64'd4);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_current <= 64'd0;
    end else begin
      pc_current <= pc_next;
    end
  end
endmodule

// File: tb/tb_rv64_single_cycle_processor.sv
// Bench for rv64_single_cycle_processor: an ISA-level interpreter tracks architectural
// state and is compared against the core every cycle, plus hand-computed spot values.

module tb_rv64_single_cycle_processor;
  localparam int IMEM_DEPTH = 256;
  localparam int DMEM_DEPTH = 256;

  logic clk = 1'b0;
  logic reset = 1'b0;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  logic [31:0] m_imem [0:IMEM_DEPTH-1];
  logic [63:0] m_dmem [0:DMEM_DEPTH-1];
  logic [63:0] m_regs [0:31];
  logic [63:0] m_pc;
  logic [31:0] prog [$];

  rv64_single_cycle_processor #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
    .clk   (clk),
    .reset (reset)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  // ---------------- ISA model ----------------
  task automatic m_write(input logic [4:0] rd, input logic [63:0] v);
    if (rd != 5'd0) m_regs[rd] = v;
  endtask

  task automatic model_step();
    logic [31:0] ins;
    logic [63:0] a, b, imm_i, imm_s, imm_b, nxt;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [5:0]  sh;
    int          di;
    ins   = m_imem[int'((m_pc / 64'd4) % 64'(IMEM_DEPTH))];
    op    = ins[6:0];
    rd    = ins[11:7];
    f3    = ins[14:12];
    f7    = ins[31:25];
    a     = (ins[19:15] == 5'd0) ? 64'd0 : m_regs[ins[19:15]];
    b     = (ins[24:20] == 5'd0) ? 64'd0 : m_regs[ins[24:20]];
    sh    = b[5:0];
    imm_i = 64'($signed(ins[31:20]));
    imm_s = 64'($signed({ins[31:25], ins[11:7]}));
    imm_b = 64'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    nxt   = m_pc + 64'd4;
    case (op)
      7'b0000011: if (f3 == 3'd3) begin
        di = int'(((a + imm_i) / 64'd8) % 64'(DMEM_DEPTH));
        m_write(rd, m_dmem[di]);
      end
      7'b0100011: if (f3 == 3'd3) begin
        di = int'(((a + imm_s) / 64'd8) % 64'(DMEM_DEPTH));
        m_dmem[di] = b;
      end
      7'b0010011: if (f3 == 3'd0) m_write(rd, a + imm_i);
      7'b1100011: if (f3 == 3'd0 && a == b) nxt = m_pc + imm_b;
      7'b0110011: begin
        case ({f7, f3})
          {7'h00, 3'd0}: m_write(rd, a + b);
          {7'h20, 3'd0}: m_write(rd, a - b);
          {7'h00, 3'd1}: m_write(rd, a << sh);
          {7'h00, 3'd2}: m_write(rd, ($signed(a) < $signed(b)) ? 64'd1 : 64'd0);
          {7'h00, 3'd3}: m_write(rd, (a < b) ? 64'd1 : 64'd0);
          {7'h00, 3'd4}: m_write(rd, a ^ b);
          {7'h00, 3'd5}: m_write(rd, a >> sh);
          {7'h20, 3'd5}: m_write(rd, 64'($signed(a) >>> sh));
          {7'h00, 3'd6}: m_write(rd, a | b);
          {7'h00, 3'd7}: m_write(rd, a & b);
          default: ;
        endcase
      end
      default: ;
    endcase
    m_pc = nxt;
  endtask

  always @(posedge clk) begin
    if (reset && chk_en) model_step();
  end

  // ---------------- scoreboard ----------------
  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : compare
    int bad;
    if (chk_en) begin
      check64("pc", dut.pc_current, m_pc);
      bad = -1;
      for (int i = 0; i < 32; i++)
        if (bad < 0 && dut.id_stage.registers[i] !== m_regs[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_errors++;
        $display("FAIL regs x%0d: got %h expected %h", bad, dut.id_stage.registers[bad], m_regs[bad]);
      end
      bad = -1;
      for (int i = 0; i < DMEM_DEPTH; i++)
        if (bad < 0 && dut.mem_stage.mem[i] !== m_dmem[i]) bad = i;
      n_checks++;
      if (bad >= 0) begin
        n_errors++;
        $display("FAIL dmem[%0d]: got %h expected %h", bad, dut.mem_stage.mem[bad], m_dmem[bad]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [63:0] x18_val);
    for (int i = 0; i < IMEM_DEPTH; i++) begin
      m_imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
      dut.if_stage.instr_mem[i] = m_imem[i];
    end
    for (int i = 0; i < DMEM_DEPTH; i++) m_dmem[i] = 64'hD000_0000_0000_0000 + 64'(i) * 64'h101;
    m_dmem[32] = 64'h1234_5678_90AB_CDEF;
    m_dmem[63] = 64'hCAFE_F00D_1234_5678;
    for (int i = 0; i < DMEM_DEPTH; i++) dut.mem_stage.mem[i] = m_dmem[i];
    for (int i = 0; i < 32; i++) m_regs[i] = (i == 0) ? 64'd0 : 64'h1000 + 64'(i);
    m_regs[5]  = 64'd5;
    m_regs[6]  = 64'd6;
    m_regs[7]  = 64'hFFFF_FFFF_FFFF_FF00;
    m_regs[9]  = 64'h800;
    m_regs[14] = 64'h100;
    m_regs[16] = 64'h200;
    m_regs[17] = 64'd1;
    m_regs[18] = x18_val;
    m_regs[23] = 64'h55;
    for (int i = 0; i < 32; i++) dut.id_stage.registers[i] = m_regs[i];
    m_pc = 64'd0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    prog.push_back(32'h00073A03);                                // 0x00 ld  x20,0(x14)
    prog.push_back(32'h00530AB3);                                // 0x04 add x21,x6,x5
    prog.push_back(32'h01583023);                                // 0x08 sd  x21,0(x16)
    prog.push_back(32'h01288863);                                // 0x0C beq x17,x18,+16
    prog.push_back(32'h00000013);                                // 0x10 nop
    prog.push_back(enc_i(12'd99, 5'd0, 3'd0, 5'd23, 7'h13));     // 0x14 addi x23,x0,99
    prog.push_back(enc_i(12'd1, 5'd23, 3'd0, 5'd23, 7'h13));     // 0x18 addi x23,x23,1
    prog.push_back(enc_r(7'h20, 5'd5, 5'd6, 3'd0, 5'd22));       // 0x1C sub  x22,x6,x5
    prog.push_back(enc_r(7'h00, 5'd5, 5'd6, 3'd7, 5'd24));       // 0x20 and  x24
    prog.push_back(enc_r(7'h00, 5'd5, 5'd6, 3'd6, 5'd25));       // 0x24 or   x25
    prog.push_back(enc_r(7'h00, 5'd5, 5'd6, 3'd0, 5'd0));        // 0x28 add  x0
    prog.push_back(enc_r(7'h00, 5'd5, 5'd6, 3'd4, 5'd26));       // 0x2C xor  x26
    prog.push_back(enc_r(7'h00, 5'd6, 5'd5, 3'd1, 5'd27));       // 0x30 sll  x27,x5,x6
    prog.push_back(enc_r(7'h20, 5'd5, 5'd7, 3'd5, 5'd28));       // 0x34 sra  x28,x7,x5
    prog.push_back(enc_r(7'h00, 5'd5, 5'd7, 3'd5, 5'd29));       // 0x38 srl  x29,x7,x5
    prog.push_back(enc_r(7'h00, 5'd5, 5'd7, 3'd2, 5'd30));       // 0x3C slt  x30
    prog.push_back(enc_r(7'h00, 5'd5, 5'd7, 3'd3, 5'd31));       // 0x40 sltu x31
    prog.push_back(enc_i(12'hFFF, 5'd7, 3'd0, 5'd1, 7'h13));     // 0x44 addi x1,x7,-1
    prog.push_back(enc_s(12'd8, 5'd21, 5'd9));                   // 0x48 sd   x21,8(x9) wraps
    prog.push_back(enc_i(12'hFF8, 5'd16, 3'd3, 5'd2, 7'h03));    // 0x4C ld   x2,-8(x16)
    prog.push_back(32'h00000000);                                // 0x50 unsupported
    prog.push_back(enc_b(13'h1FF8, 5'd0, 5'd0));                 // 0x54 beq  x0,x0,-8

    // Phase 1: preload under reset, taken branch, full ALU sweep
    reset = 1'b0;
    preload(64'd1);
    chk_en = 1'b1;
    #1;
    check64("reset_pc", dut.pc_current, 64'd0);
    step(1);
    reset = 1'b1;
    step(1);
    check64("ld_pc", dut.pc_current, 64'h4);
    check64("ld_x20", dut.id_stage.registers[20], 64'h1234_5678_90AB_CDEF);
    step(1);
    check64("add_x21", dut.id_stage.registers[21], 64'hB);
    step(1);
    check64("sd_mem64", dut.mem_stage.mem[64], 64'hB);
    check64("sd_pc", dut.pc_current, 64'hC);
    step(1);
    check64("beq_taken_pc", dut.pc_current, 64'h1C);
    step(16);
    check64("sub_x22", dut.id_stage.registers[22], 64'd1);
    check64("and_x24", dut.id_stage.registers[24], 64'd4);
    check64("or_x25", dut.id_stage.registers[25], 64'd7);
    check64("x0_zero", dut.id_stage.registers[0], 64'd0);
    check64("xor_x26", dut.id_stage.registers[26], 64'd3);
    check64("sll_x27", dut.id_stage.registers[27], 64'h140);
    check64("sra_x28", dut.id_stage.registers[28], 64'hFFFF_FFFF_FFFF_FFF8);
    check64("srl_x29", dut.id_stage.registers[29], 64'h07FF_FFFF_FFFF_FFF8);
    check64("slt_x30", dut.id_stage.registers[30], 64'd1);
    check64("sltu_x31", dut.id_stage.registers[31], 64'd0);
    check64("addi_x1", dut.id_stage.registers[1], 64'hFFFF_FFFF_FFFF_FEFF);
    check64("skipped_x23", dut.id_stage.registers[23], 64'h55);
    check64("sd_wrap_mem1", dut.mem_stage.mem[1], 64'hB);
    check64("ld_neg_x2", dut.id_stage.registers[2], 64'hCAFE_F00D_1234_5678);
    check64("back_branch_pc", dut.pc_current, 64'h50);

    // Phase 2: branch not taken, then asynchronous reset between edges
    reset = 1'b0;
    m_pc = 64'd0;
    #1;
    check64("async_reset_pc", dut.pc_current, 64'd0);
    preload(64'd2);
    step(1);
    reset = 1'b1;
    step(4);
    check64("beq_not_taken_pc", dut.pc_current, 64'h10);
    step(3);
    check64("addi_x23", dut.id_stage.registers[23], 64'd100);
    step(2);
    #2;
    reset = 1'b0;
    m_pc = 64'd0;
    #1;
    check64("midrun_reset_pc", dut.pc_current, 64'd0);
    m_dmem[32] = 64'h0F0F_0F0F_0F0F_0F0F;
    dut.mem_stage.mem[32] = m_dmem[32];
    step(3);
    check64("hold_pc", dut.pc_current, 64'd0);
    check64("hold_x20", dut.id_stage.registers[20], 64'h1234_5678_90AB_CDEF);
    check64("hold_mem64", dut.mem_stage.mem[64], 64'hB);
    reset = 1'b1;
    step(1);
    check64("restart_pc", dut.pc_current, 64'h4);
    check64("restart_x20", dut.id_stage.registers[20], 64'h0F0F_0F0F_0F0F_0F0F);
    step(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rv64_single_cycle_processor.md
Name: rv64_single_cycle_processor

Overview:
Single-cycle RV64I-subset CPU core: fetch, decode, execute, memory and writeback all complete in one clock. It contains its own instruction memory, 32x64 register file and 64-bit data memory, and has no external bus. Verification preloads the memories and registers hierarchically and checks architectural state.

Parameters:
IMEM_DEPTH, 256, number of 32-bit instruction words; index = pc[63:2].
DMEM_DEPTH, 256, number of 64-bit data doublewords; index = addr[63:3].

Ports:
clk  input  1  single clock, all state updates on rising edge.
reset  input  1  asynchronous, active-low reset; the port keeps the codebase name "reset".

Behaviour:
- Reset asserted (reset=0): pc_current=0 immediately (async). Register file, instruction memory and data memory are NOT cleared, so the bench can preload them while in reset. No writes occur while reset is asserted.
- Each rising edge with reset deasserted: one instruction retires. The PC, register write and memory store all update on that edge.
- Fetch: instruction = instr_mem[pc_current>>2], combinational.
- Decode: combinational reads rs1/rs2; x0 reads 0 and writes to x0 are ignored. Immediates are sign-extended to 64 bits:
  - I-type: inst[31:20].
  - S-type: {inst[31:25],inst[11:7]}.
  - SB-type: {inst[31],inst[7],inst[30:25],inst[11:8],0}, a byte offset.
- Supported opcodes:
  - 0000011 ld (funct3 011): rd = dmem[(rs1+imm)>>3].
  - 0100011 sd (funct3 011): dmem[(rs1+imm)>>3] = rs2.
  - 0110011 R-type: add (f3 000, f7 0000000), sub (f3 000, f7 0100000), and (111), or (110), xor (100), sll (001), srl (101, f7 0), sra (101, f7 0100000), slt (010), sltu (011). Shift amount = rs2[5:0].
  - 0010011 addi (f3 000): rd = rs1+imm. Encoding 0x00000013 is the nop.
  - 1100011 beq (f3 000): if rs1==rs2, next PC = pc+imm, else pc+4.
- Any other opcode (including 0x00000000): no register write, no memory write, PC += 4.
- Control signals: reg_write, alu_src, alu_op[1:0] (00 add for ld/sd/addi, 01 sub for beq, 10 funct-decoded for R-type), branch, mem_read, mem_write, mem_to_reg.
- Branch rule: branch_taken = branch & zero, where zero = (alu_result==0).
- Writeback: write_data_reg = mem_to_reg ? read_data_mem : alu_result.
- Data memory: read is combinational; write is synchronous.
- All arithmetic is 64-bit modulo 2^64, with no overflow trap.
- Addresses outside the memory depth: index wraps modulo depth. Low address bits below word/doubleword alignment are ignored.
- Required hierarchical names:
  - Top-level signals: pc_current, instruction, read_data1, read_data2, imm_ext, reg_write, alu_src, alu_op, branch, mem_read, mem_write, mem_to_reg, alu_result, zero, branch_taken, alu_result_mem, read_data_mem, write_reg, write_data_reg, reg_write_wb.
  - Submodule arrays: if_stage.instr_mem[], id_stage.registers[], mem_stage.mem[].

Test Plan:
- Reset: hold reset=0, preload regs and memories, then release → pc_current=0 and preloaded values are intact; the first instruction executes on the first edge.
- Load: x14=0x100, mem[32]=0x1234567890ABCDEF, instruction 0x00073A03 (ld x20,0(x14)) → x20=0x1234567890ABCDEF, PC 0→4.
- ALU: x5=5, x6=6, instruction 0x00530AB3 (add x21,x6,x5) → x21=0xB. Also cover sub, and, or, and a write to x0, which must stay 0.
- Store: x16=0x200, instruction 0x01583023 (sd x21,0(x16)) → mem[64]=0xB with no register write.
- Branch taken: x17=x18=1, beq at PC 0xC (0x01288863, offset 16) → PC=0x1C and the nop at 0x10 is skipped. Also cover not-taken (x18=2) → PC=0x10.
- Async reset mid-run: drive reset low between edges → PC=0 immediately, with no further register or memory writes.
